tarih_uart_raporlayici: RTL and testbench

//  UART reporting stage between the uart_rx and uart_tx instances of the calendar/clock top.
//  - On a command byte from uart_rx, snapshots the current date/time fields.
//  - Converts them to ASCII decimal and streams "DD.MM.YYYY HH:MM:SS" byte-by-byte into uart_tx.
//  - Paces the stream with the uart_tx_busy handshake.

---
 rtl/tarih_uart_raporlayici.sv | 243 ++++++++++++++++++++++++
 tb/tb_tarih_uart_raporlayici.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tarih_uart_raporlayici.sv
// -----------------------------------------------------------------------------
// tarih_uart_raporlayici
//
// Sits between uart_rx and uart_tx of the calendar/clock top. When the command
// byte arrives it snapshots the date/time fields and streams them out as
// "DD.MM.YYYY HH:MM:SS" in ASCII, one byte per uart_tx load. Each load is paced
// by uart_tx_busy: wait for idle, strobe, wait for busy to rise, wait for busy
// to fall.
//
// Optional feature macro: RAPOR_CRLF_EN
//   defined   -> 0x0D 0x0A are appended after the seconds (21-byte report)
//   undefined -> 19-byte report ending with the seconds ones digit
//
// Ports
//   CLK            in   system clock
//   resetn         in   synchronous reset, active low
//   uart_rx_data   in   [7:0] received byte
//   uart_rx_valid  in   1-cycle strobe qualifying uart_rx_data
//   gun/ay/yil     in   day [4:0], month [3:0], year [11:0]
//   saat/dakika/saniye in hour [4:0], minute [5:0], second [5:0]
//   uart_tx_busy   in   transmitter is shifting a byte
//   uart_tx_en     out  1-cycle strobe loading uart_tx_data into uart_tx
//   uart_tx_data   out  [7:0] byte to send, holds between strobes
//   rapor_mesgul   out  report in progress
//   rapor_bitti    out  1-cycle pulse, last byte completed
//   rapor_hata     out  1-cycle pulse, aborted because busy never rose
//
// Handshake: uart_tx_en is asserted combinationally only while in GONDER and
// uart_tx_busy is low, so a byte is offered exactly in the first idle cycle
// and the strobe lasts one cycle because the state advances on that edge.
// -----------------------------------------------------------------------------
module tarih_uart_raporlayici #(
    parameter logic [7:0] KOMUT_KARAKTERI = 8'h54,
    parameter int         BUSY_TIMEOUT    = 1023   // must be >= 2
) (
    input  logic        CLK,
    input  logic        resetn,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    input  logic [4:0]  gun,
    input  logic [3:0]  ay,
    input  logic [11:0] yil,
    input  logic [4:0]  saat,
    input  logic [5:0]  dakika,
    input  logic [5:0]  saniye,
    input  logic        uart_tx_busy,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    output logic        rapor_mesgul,
    output logic        rapor_bitti,
    output logic        rapor_hata
);

    localparam logic [2:0] BOSTA        = 3'd0;
    localparam logic [2:0] CEVIR        = 3'd1;
    localparam logic [2:0] GONDER       = 3'd2;
    localparam logic [2:0] MESGUL_BEKLE = 3'd3;
    localparam logic [2:0] BITIS_BEKLE  = 3'd4;

`ifdef RAPOR_CRLF_EN
    localparam int RAPOR_UZUNLUK = 21;
`else
    localparam int RAPOR_UZUNLUK = 19;
`endif
    localparam logic [4:0] SON_INDEKS = 5'(RAPOR_UZUNLUK - 1);

    // The strobe cycle counts as the first of the BUSY_TIMEOUT cycles and the
    // abort edge as the last, so the counter stops at BUSY_TIMEOUT-2.
    localparam int         TW       = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_SON = TW'(BUSY_TIMEOUT - 2);
    localparam logic [TW-1:0] TMO_BIR = TW'(1);

    logic [2:0]    r_durum;
    logic [4:0]    r_gun;
    logic [3:0]    r_ay;
    logic [4:0]    r_saat;
    logic [5:0]    r_dakika;
    logic [5:0]    r_saniye;
    logic [11:0]   r_yil_kaydir;
    logic [15:0]   r_bcd;
    logic [3:0]    r_dd_sayac;
    logic [4:0]    r_indeks;
    logic [TW-1:0] r_tmo;
    logic [7:0]    r_veri;
    logic          r_mesgul;
    logic          r_bitti;
    logic          r_hata;

    logic [15:0]   w_bcd_duzelt;
    logic [7:0]    w_bayt;
    logic          w_tx_en;

    function automatic logic [3:0] onlar(input logic [5:0] v);
        logic [5:0] q;
        q = v / 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [3:0] birler(input logic [5:0] v);
        logic [5:0] q;
        q = v % 6'd10;
        return q[3:0];
    endfunction

    function automatic logic [7:0] rakam(input logic [3:0] d);
        return 8'h30 + {4'h0, d};
    endfunction

    // Double-dabble add-3 step on every BCD nibble before the shift.
    always_comb begin
        w_bcd_duzelt = r_bcd;
        for (int k = 0; k < 4; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_duzelt[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Byte selected by the current index.
    always_comb begin
        w_bayt = 8'h00;
        case (r_indeks)
            5'd0:    w_bayt = rakam(onlar({1'b0, r_gun}));
            5'd1:    w_bayt = rakam(birler({1'b0, r_gun}));
            5'd2:    w_bayt = 8'h2E;
            5'd3:    w_bayt = rakam(onlar({2'b00, r_ay}));
            5'd4:    w_bayt = rakam(birler({2'b00, r_ay}));
            5'd5:    w_bayt = 8'h2E;
            5'd6:    w_bayt = rakam(r_bcd[15:12]);
            5'd7:    w_bayt = rakam(r_bcd[11:8]);
            5'd8:    w_bayt = rakam(r_bcd[7:4]);
            5'd9:    w_bayt = rakam(r_bcd[3:0]);
            5'd10:   w_bayt = 8'h20;
            5'd11:   w_bayt = rakam(onlar({1'b0, r_saat}));
            5'd12:   w_bayt = rakam(birler({1'b0, r_saat}));
            5'd13:   w_bayt = 8'h3A;
            5'd14:   w_bayt = rakam(onlar(r_dakika));
            5'd15:   w_bayt = rakam(birler(r_dakika));
            5'd16:   w_bayt = 8'h3A;
            5'd17:   w_bayt = rakam(onlar(r_saniye));
            5'd18:   w_bayt = rakam(birler(r_saniye));
`ifdef RAPOR_CRLF_EN
            5'd19:   w_bayt = 8'h0D;
            5'd20:   w_bayt = 8'h0A;
`endif
            default: w_bayt = 8'h00;
        endcase
    end

    assign w_tx_en      = (r_durum == GONDER) && !uart_tx_busy;
    assign uart_tx_en   = w_tx_en;
    assign uart_tx_data = w_tx_en ? w_bayt : r_veri;
    assign rapor_mesgul = r_mesgul;
    assign rapor_bitti  = r_bitti;
    assign rapor_hata   = r_hata;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_durum      <= BOSTA;
            r_gun        <= '0;
            r_ay         <= '0;
            r_saat       <= '0;
            r_dakika     <= '0;
            r_saniye     <= '0;
            r_yil_kaydir <= '0;
            r_bcd        <= '0;
            r_dd_sayac   <= '0;
            r_indeks     <= '0;
            r_tmo        <= '0;
            r_veri       <= 8'h00;
            r_mesgul     <= 1'b0;
            r_bitti      <= 1'b0;
            r_hata       <= 1'b0;
        end else begin
            r_bitti <= 1'b0;
            r_hata  <= 1'b0;
            if (w_tx_en) begin
                r_veri <= w_bayt;
            end
            case (r_durum)
                BOSTA: begin
                    if (uart_rx_valid && (uart_rx_data == KOMUT_KARAKTERI)) begin
                        r_gun        <= gun;
                        r_ay         <= ay;
                        r_saat       <= saat;
                        r_dakika     <= dakika;
                        r_saniye     <= saniye;
                        r_yil_kaydir <= yil;
                        r_bcd        <= '0;
                        r_dd_sayac   <= '0;
                        r_indeks     <= '0;
                        r_mesgul     <= 1'b1;
                        r_durum      <= CEVIR;
                    end
                end
                CEVIR: begin
                    // Shift the next year bit (MSB first) into the adjusted BCD.
                    r_bcd        <= {w_bcd_duzelt[14:0], r_yil_kaydir[11]};
                    r_yil_kaydir <= {r_yil_kaydir[10:0], 1'b0};
                    r_dd_sayac   <= r_dd_sayac + 4'd1;
                    if (r_dd_sayac == 4'd11) begin
                        r_durum <= GONDER;
                    end
                end
                GONDER: begin
                    if (!uart_tx_busy) begin
                        r_tmo   <= '0;
                        r_durum <= MESGUL_BEKLE;
                    end
                end
                MESGUL_BEKLE: begin
                    if (uart_tx_busy) begin
                        r_durum <= BITIS_BEKLE;
                    end else if (r_tmo == TMO_SON) begin
                        r_hata   <= 1'b1;
                        r_mesgul <= 1'b0;
                        r_indeks <= '0;
                        r_durum  <= BOSTA;
                    end else begin
                        r_tmo <= r_tmo + TMO_BIR;
                    end
                end
                BITIS_BEKLE: begin
                    if (!uart_tx_busy) begin
                        if (r_indeks == SON_INDEKS) begin
                            r_bitti  <= 1'b1;
                            r_mesgul <= 1'b0;
                            r_indeks <= '0;
                            r_durum  <= BOSTA;
                        end else begin
                            r_indeks <= r_indeks + 5'd1;
                            r_durum  <= GONDER;
                        end
                    end
                end
                default: begin
                    r_durum <= BOSTA;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tarih_uart_raporlayici.sv
module tb_tarih_uart_raporlayici;

  localparam logic [7:0] KOMUT = 8'h54;
  localparam int         TMO   = 1023;

  // clock / reset
  logic        CLK = 1'b0;
  logic        resetn = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0]  uart_rx_data = 8'h00;
  logic        uart_rx_valid = 1'b0;
  logic [4:0]  gun = 5'd1;
  logic [3:0]  ay = 4'd1;
  logic [11:0] yil = 12'd0;
  logic [4:0]  saat = 5'd0;
  logic [5:0]  dakika = 6'd0;
  logic [5:0]  saniye = 6'd0;
  logic        uart_tx_busy = 1'b0;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        rapor_mesgul;
  logic        rapor_bitti;
  logic        rapor_hata;

  tarih_uart_raporlayici #(.KOMUT_KARAKTERI(KOMUT), .BUSY_TIMEOUT(TMO)) dut (
    .CLK(CLK), .resetn(resetn),
    .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid),
    .gun(gun), .ay(ay), .yil(yil), .saat(saat), .dakika(dakika), .saniye(saniye),
    .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
    .rapor_mesgul(rapor_mesgul), .rapor_bitti(rapor_bitti), .rapor_hata(rapor_hata)
  );

  typedef struct {
    int    g;
    int    a;
    int    y;
    int    h;
    int    d;
    int    s;
    string bek;   // expected text without line ending, empty -> use model
  } vek_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int bitti_cnt = 0;
  int hata_cnt = 0;
  bit onceki = 1'b0;
  bit tx_mode = 1'b1;
  bit en_pending = 1'b0;
  int busy_kalan = 0;

  logic [7:0] got_q[$];
  int         en_cyc_q[$];
  logic [7:0] exp_q[$];

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    if (uart_tx_en === 1'b1) begin
      got_q.push_back(uart_tx_data);
      en_cyc_q.push_back(cyc);
      en_pending = 1'b1;
    end
    if (rapor_bitti === 1'b1) bitti_cnt++;
    if (rapor_hata === 1'b1) hata_cnt++;
  end

  // uart_tx model: busy rises just after the edge that took the strobe.
  always @(posedge CLK) begin
    #1;
    if (tx_mode) begin
      if (en_pending) begin
        en_pending = 1'b0;
        uart_tx_busy = 1'b1;
        busy_kalan = $urandom_range(1, 12);
      end else if (busy_kalan > 0) begin
        busy_kalan--;
        if (busy_kalan == 0) uart_tx_busy = 1'b0;
      end
    end else begin
      en_pending = 1'b0;
      busy_kalan = 0;
      uart_tx_busy = 1'b0;
    end
  end

  task automatic chk(input string ad, input logic [31:0] gercek, input logic [31:0] gerekli);
    total++;
    if (gercek !== gerekli) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", ad, gercek, gerekli, $time);
    end
  endtask

  // Reference model: the report text straight from the field values.
  function automatic string model_metin(input vek_t v);
    return $sformatf("%02d.%02d.%04d %02d:%02d:%02d", v.g, v.a, v.y, v.h, v.d, v.s);
  endfunction

  function automatic vek_t rastgele_vek();
    vek_t v;
    v.g = $urandom_range(1, 31);
    v.a = $urandom_range(1, 12);
    v.y = $urandom_range(0, 4095);
    v.h = $urandom_range(0, 23);
    v.d = $urandom_range(0, 59);
    v.s = $urandom_range(0, 59);
    v.bek = "";
    return v;
  endfunction

  task automatic alanlar_ata(input vek_t v);
    gun = 5'(v.g);
    ay = 4'(v.a);
    yil = 12'(v.y);
    saat = 5'(v.h);
    dakika = 6'(v.d);
    saniye = 6'(v.s);
  endtask

  // Drives one rx strobe; n is the cycle whose closing edge samples it.
  task automatic cmd_gonder(input logic [7:0] b, output int n);
    @(negedge CLK);
    uart_rx_data = b;
    uart_rx_valid = 1'b1;
    n = cyc;
    @(negedge CLK);
    uart_rx_valid = 1'b0;
  endtask

  task automatic onceki_kontrol();
    if (onceki) begin
      chk("bitti_tek", bitti_cnt, 1);
      chk("hata_yok", hata_cnt, 0);
    end
    onceki = 1'b0;
  endtask

  task automatic son_kontrol();
    repeat (3) @(negedge CLK);
    onceki_kontrol();
  endtask

  task automatic rapor_calistir(input vek_t v, input bit g_once);
    int    n;
    int    m;
    bit    gordu;
    string s;
    if (g_once) begin
      cmd_gonder(8'h47, m);
      chk("g_yok_say", rapor_mesgul, 0);
    end
    s = (v.bek.len() != 0) ? v.bek : model_metin(v);
`ifdef RAPOR_CRLF_EN
    s = {s, "\r\n"};
`endif
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    alanlar_ata(v);
    cmd_gonder(KOMUT, n);
    onceki_kontrol();
    got_q.delete();
    en_cyc_q.delete();
    bitti_cnt = 0;
    hata_cnt = 0;
    chk("mesgul_basla", rapor_mesgul, 1);
    // Mid-report: new command and changed fields must not matter.
    for (int i = 0; i < 500 && got_q.size() < 5; i++) @(negedge CLK);
    alanlar_ata(rastgele_vek());
    cmd_gonder(KOMUT, m);
    gordu = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (rapor_bitti === 1'b1) begin
        gordu = 1'b1;
        chk("mesgul_bitti", rapor_mesgul, 0);
        break;
      end
    end
    chk("bitti_geldi", gordu, 1);
    chk("bayt_sayisi", got_q.size(), exp_q.size());
    if (en_cyc_q.size() > 0) chk("ilk_en_gecikme", en_cyc_q[0] - n, 13);
    for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
      chk($sformatf("bayt%0d", i), got_q[i], exp_q.pop_front());
    end
    onceki = 1'b1;
  endtask

  vek_t tablo[8];

  initial begin
    int n;
    int sz;
    int hcyc;
    bit gordu;

    tablo[0] = '{30, 7, 2024, 18, 30, 5, "30.07.2024 18:30:05"};
    tablo[1] = '{1, 1, 4095, 23, 59, 59, "01.01.4095 23:59:59"};
    tablo[2] = '{5, 12, 7, 0, 0, 0, "05.12.0007 00:00:00"};
    tablo[3] = '{31, 10, 0, 9, 5, 1, "31.10.0000 09:05:01"};
    for (int i = 4; i < 8; i++) tablo[i] = rastgele_vek();

    // 1: reset held 3 cycles, then quiet for 100 cycles
    resetn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_en", uart_tx_en, 0);
    chk("rst_data", uart_tx_data, 8'h00);
    chk("rst_mesgul", rapor_mesgul, 0);
    chk("rst_bitti", rapor_bitti, 0);
    chk("rst_hata", rapor_hata, 0);
    resetn = 1'b1;
    repeat (100) @(negedge CLK);
    chk("rst_sessiz", got_q.size(), 0);

    // 2-4: table of reports, back to back
    for (int i = 0; i < 8; i++) rapor_calistir(tablo[i], i == 0);
    son_kontrol();

    // 5: busy never rises -> timeout
    tx_mode = 1'b0;
    got_q.delete();
    en_cyc_q.delete();
    bitti_cnt = 0;
    hata_cnt = 0;
    cmd_gonder(KOMUT, n);
    gordu = 1'b0;
    hcyc = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge CLK);
      if (rapor_hata === 1'b1) begin
        gordu = 1'b1;
        hcyc = cyc;
        chk("tmo_mesgul", rapor_mesgul, 0);
        break;
      end
    end
    chk("tmo_hata_geldi", gordu, 1);
    chk("tmo_en_sayisi", en_cyc_q.size(), 1);
    if (en_cyc_q.size() > 0) begin
      chk("tmo_ilk_en", en_cyc_q[0] - n, 13);
      chk("tmo_sure", hcyc - en_cyc_q[0], TMO);
    end
    repeat (3) @(negedge CLK);
    chk("tmo_hata_tek", hata_cnt, 1);
    chk("tmo_bitti_yok", bitti_cnt, 0);
    tx_mode = 1'b1;
    rapor_calistir(rastgele_vek(), 1'b0);
    son_kontrol();

    // 6: reset after the 5th byte
    got_q.delete();
    alanlar_ata(tablo[0]);
    cmd_gonder(KOMUT, n);
    for (int i = 0; i < 500 && got_q.size() < 5; i++) @(negedge CLK);
    resetn = 1'b0;
    repeat (2) @(negedge CLK);
    resetn = 1'b1;
    chk("rst2_en", uart_tx_en, 0);
    chk("rst2_data", uart_tx_data, 8'h00);
    chk("rst2_mesgul", rapor_mesgul, 0);
    bitti_cnt = 0;
    sz = got_q.size();
    repeat (300) @(negedge CLK);
    chk("rst2_bayt_yok", got_q.size(), sz);
    chk("rst2_bitti_yok", bitti_cnt, 0);
    rapor_calistir(tablo[1], 1'b0);
    son_kontrol();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
